gpu_vram_write_ctrl: RTL and testbench

CPU-facing register front-end and write sequencer for the 32KB graphics VRAM write port. It has a small 8-register window with an auto-incrementing address pointer and an optional row-stride step. A hardware fill engine clears or fills any VRAM span at one byte per clock. The block is the sole driver of the VRAM write port (addr/data/we) and runs in the clk_cpu domain.

---
 rtl/gpu_vram_write_ctrl_pkg.sv | 33 +++
 rtl/gpu_vram_fill_engine.sv | 62 ++++++
 rtl/gpu_vram_write_ctrl.sv | 124 ++++++++++++
 tb/tb_gpu_vram_write_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_vram_write_ctrl_pkg.sv
// Shared constants for the VRAM write controller: register map, CTRL/STATUS
// bit positions, default geometry and fill-engine state encoding.
package gpu_vram_write_ctrl_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 15;
  localparam int unsigned ROW_STRIDE_DEF  = 40;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned FILL_LEN_W      = 15;

  localparam logic [2:0] REG_ADDR_LO     = 3'd0;
  localparam logic [2:0] REG_ADDR_HI     = 3'd1;
  localparam logic [2:0] REG_DATA        = 3'd2;
  localparam logic [2:0] REG_CTRL        = 3'd3;
  localparam logic [2:0] REG_FILL_VAL    = 3'd4;
  localparam logic [2:0] REG_FILL_LEN_LO = 3'd5;
  localparam logic [2:0] REG_FILL_LEN_HI = 3'd6;
  localparam logic [2:0] REG_CMD         = 3'd7;

  localparam int unsigned CTRL_AUTO_INC = 0;
  localparam int unsigned CTRL_STEP     = 1;
  localparam int unsigned CTRL_CLR_OVR  = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic step;
    logic auto_inc;
  } ctrl_t;

endpackage

// File: rtl/gpu_vram_fill_engine.sv
// Fill sequencer: counts down FILL_LEN bytes, requests one VRAM write per
// clock and pulses fill_done in the cycle after the last write.
module gpu_vram_fill_engine
  import gpu_vram_write_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = FILL_LEN_W
) (
  input  logic             clk_cpu,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] fill_len,
  output logic             busy,
  output logic             fill_done,
  output logic             issue_c
);

  fill_state_e      state;
  logic [LEN_W-1:0] cnt;
  logic             launch_c;

  // The first write is issued on the START edge itself so it lands one cycle
  // after START, like a DATA write; cnt then counts writes still on the bus.
  always_comb begin
    launch_c = (state == ST_IDLE) && start && (fill_len != '0);
    issue_c  = launch_c || ((state == ST_FILL) && (cnt > LEN_W'(1)));
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_c) begin
            state <= ST_FILL;
            cnt   <= fill_len;
            busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (cnt == LEN_W'(1)) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            fill_done <= 1'b1;
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpu_vram_write_ctrl.sv
// CPU register window and sole driver of the VRAM write port: pointer with
// auto-increment/row-stride, direct DATA writes and a hardware fill engine.
module gpu_vram_write_ctrl
  import gpu_vram_write_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEF
) (
  input  logic                  clk_cpu,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [2:0]            reg_addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_W-1:0]     vram_data,
  output logic                  vram_we,
  output logic                  busy,
  output logic                  fill_done
);

  localparam int unsigned HI_W     = ADDR_WIDTH - 8;
  localparam int unsigned LEN_HI_W = FILL_LEN_W - 8;

  logic [ADDR_WIDTH-1:0] ptr;
  ctrl_t                 ctrl;
  logic [DATA_W-1:0]     fill_val;
  logic [FILL_LEN_W-1:0] fill_len;
  logic                  overrun;

  logic                  wr_c;
  logic                  data_wr_c;
  logic                  start_c;
  logic                  fill_issue_c;
  logic [ADDR_WIDTH-1:0] step_c;

  always_comb begin
    wr_c      = cs & we;
    data_wr_c = wr_c && (reg_addr == REG_DATA);
    start_c   = wr_c && (reg_addr == REG_CMD) && !busy;
    step_c    = ctrl.step ? ADDR_WIDTH'(ROW_STRIDE) : ADDR_WIDTH'(1);
  end

  gpu_vram_fill_engine #(
    .LEN_W (FILL_LEN_W)
  ) u_fill (
    .clk_cpu   (clk_cpu),
    .rst_n     (rst_n),
    .start     (start_c),
    .fill_len  (fill_len),
    .busy      (busy),
    .fill_done (fill_done),
    .issue_c   (fill_issue_c)
  );

  // Register file, pointer update and registered VRAM write port.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      ctrl      <= '0;
      fill_val  <= '0;
      fill_len  <= '0;
      overrun   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
      vram_we   <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      if (fill_issue_c) begin
        vram_we   <= 1'b1;
        vram_addr <= ptr;
        vram_data <= fill_val;
        ptr       <= ptr + ADDR_WIDTH'(1);
      end else if (data_wr_c && !busy) begin
        vram_we   <= 1'b1;
        vram_addr <= ptr;
        vram_data <= wdata;
        if (ctrl.auto_inc) begin
          ptr <= ptr + step_c;
        end
      end

      // A DATA write that collides with a running fill is lost; flag it.
      if (data_wr_c && busy) begin
        overrun <= 1'b1;
      end

      if (wr_c && !busy) begin
        case (reg_addr)
          REG_ADDR_LO:     ptr[7:0]              <= wdata;
          REG_ADDR_HI:     ptr[ADDR_WIDTH-1:8]   <= wdata[HI_W-1:0];
          REG_FILL_VAL:    fill_val              <= wdata;
          REG_FILL_LEN_LO: fill_len[7:0]         <= wdata;
          REG_FILL_LEN_HI: fill_len[FILL_LEN_W-1:8] <= wdata[LEN_HI_W-1:0];
          default: ;
        endcase
      end

      if (wr_c && (reg_addr == REG_CTRL)) begin
        ctrl.auto_inc <= wdata[CTRL_AUTO_INC];
        ctrl.step     <= wdata[CTRL_STEP];
        if (wdata[CTRL_CLR_OVR]) begin
          overrun <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      REG_ADDR_LO:     rdata = ptr[7:0];
      REG_ADDR_HI:     rdata = DATA_W'(ptr[ADDR_WIDTH-1:8]);
      REG_CTRL:        rdata = {6'b0, ctrl.step, ctrl.auto_inc};
      REG_FILL_VAL:    rdata = fill_val;
      REG_FILL_LEN_LO: rdata = fill_len[7:0];
      REG_FILL_LEN_HI: rdata = DATA_W'(fill_len[FILL_LEN_W-1:8]);
      REG_CMD:         rdata = {6'b0, overrun, busy};
      default:         rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpu_vram_write_ctrl.sv
// Directed bench for gpu_vram_write_ctrl: pointer stepping, wrap, fill
// sequencing, busy-time protection and reset abort.
module tb_gpu_vram_write_ctrl;
  import gpu_vram_write_ctrl_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [2:0]  reg_addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [14:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        busy;
  logic        fill_done;

  int passed = 0;
  int total  = 0;
  int bad;
  int nwr;

  always #5 clk_cpu = ~clk_cpu;

  gpu_vram_write_ctrl dut (
    .clk_cpu   (clk_cpu),
    .rst_n     (rst_n),
    .cs        (cs),
    .we        (we),
    .reg_addr  (reg_addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_we   (vram_we),
    .busy      (busy),
    .fill_done (fill_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_cpu);
    cs = 1'b1; we = 1'b1; reg_addr = a; wdata = d;
  endtask

  task automatic idle();
    @(negedge clk_cpu);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk_cpu);
    cs = 1'b1; we = 1'b0; reg_addr = a;
    #1;
    check(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic chk_wr(input logic [14:0] a, input logic [7:0] d, input string tag);
    check({tag, "_we"}, 32'(vram_we), 32'd1);
    check({tag, "_addr"}, 32'(vram_addr), 32'(a));
    check({tag, "_data"}, 32'(vram_data), 32'(d));
  endtask

  initial begin
    logic [14:0] ea;
    rst_n = 1'b1; cs = 1'b0; we = 1'b0; reg_addr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_cpu);
    #1;
    check("rst_vram_we", 32'(vram_we), 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_vram_data", 32'(vram_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    rd(REG_ADDR_HI, 8'h00, "rst_addr_hi");
    rd(REG_CMD, 8'h00, "rst_status");
    @(negedge clk_cpu); rst_n = 1'b1;

    // Auto-increment by one from 0x0100
    set_wr(REG_ADDR_LO, 8'h00);
    set_wr(REG_ADDR_HI, 8'h01);
    set_wr(REG_CTRL, 8'h01);
    set_wr(REG_DATA, 8'hAA); @(posedge clk_cpu); #1; chk_wr(15'h0100, 8'hAA, "inc0");
    set_wr(REG_DATA, 8'hBB); @(posedge clk_cpu); #1; chk_wr(15'h0101, 8'hBB, "inc1");
    set_wr(REG_DATA, 8'hCC); @(posedge clk_cpu); #1; chk_wr(15'h0102, 8'hCC, "inc2");
    idle(); @(posedge clk_cpu); #1;
    check("no_write_idle", 32'(vram_we), 32'd0);
    rd(REG_ADDR_LO, 8'h03, "ptr_lo_after_inc");
    rd(REG_ADDR_HI, 8'h01, "ptr_hi_after_inc");
    rd(REG_DATA, 8'h00, "data_reads_zero");
    rd(REG_CTRL, 8'h01, "ctrl_readback");

    // Wrap at top of VRAM, then row stride across the wrap
    set_wr(REG_ADDR_LO, 8'hFF);
    set_wr(REG_ADDR_HI, 8'h7F);
    set_wr(REG_DATA, 8'h11); @(posedge clk_cpu); #1; chk_wr(15'h7FFF, 8'h11, "wrap");
    rd(REG_ADDR_LO, 8'h00, "wrap_ptr_lo");
    rd(REG_ADDR_HI, 8'h00, "wrap_ptr_hi");
    set_wr(REG_CTRL, 8'h03);
    set_wr(REG_ADDR_LO, 8'hF0);
    set_wr(REG_ADDR_HI, 8'h7F);
    set_wr(REG_DATA, 8'h22); @(posedge clk_cpu); #1; chk_wr(15'h7FF0, 8'h22, "stride");
    rd(REG_ADDR_LO, 8'h18, "stride_ptr_lo");
    rd(REG_ADDR_HI, 8'h00, "stride_ptr_hi");
    set_wr(REG_CTRL, 8'h00);
    set_wr(REG_DATA, 8'h33); @(posedge clk_cpu); #1; chk_wr(15'h0018, 8'h33, "noinc");
    rd(REG_ADDR_LO, 8'h18, "noinc_ptr_lo");

    // 8000-byte fill from 0x2000 with protected-register pokes mid-fill
    set_wr(REG_CTRL, 8'h03);
    set_wr(REG_FILL_VAL, 8'h00);
    set_wr(REG_FILL_LEN_LO, 8'h40);
    set_wr(REG_FILL_LEN_HI, 8'h1F);
    set_wr(REG_ADDR_LO, 8'h00);
    set_wr(REG_ADDR_HI, 8'h20);
    set_wr(REG_CMD, 8'h00);
    @(posedge clk_cpu); #1;
    bad = 0;
    for (int i = 0; i < 8000; i++) begin
      ea = 15'h2000 + 15'(i);
      if (vram_we !== 1'b1 || vram_addr !== ea || vram_data !== 8'h00 ||
          busy !== 1'b1 || fill_done !== 1'b0) bad++;
      if (i == 0) chk_wr(15'h2000, 8'h00, "fill_first");
      if (i == 7999) chk_wr(15'h3F3F, 8'h00, "fill_last");
      if (i == 151) check("status_mid_fill", 32'(rdata), 32'h03);
      @(negedge clk_cpu);
      cs = 1'b1; we = 1'b1;
      case (i)
        100:     begin reg_addr = REG_DATA;        wdata = 8'h77; end
        101:     begin reg_addr = REG_ADDR_LO;     wdata = 8'h55; end
        102:     begin reg_addr = REG_CMD;         wdata = 8'h00; end
        103:     begin reg_addr = REG_FILL_LEN_LO; wdata = 8'h01; end
        104:     begin reg_addr = REG_FILL_VAL;    wdata = 8'hEE; end
        105:     begin reg_addr = REG_ADDR_HI;     wdata = 8'h00; end
        150:     begin we = 1'b0; reg_addr = REG_CMD; end
        default: begin cs = 1'b0; we = 1'b0; end
      endcase
      @(posedge clk_cpu); #1;
    end
    check("fill_bad_cycles", 32'(bad), 32'd0);
    check("fill_done_pulse", 32'(fill_done), 32'd1);
    check("fill_busy_low", 32'(busy), 32'd0);
    check("fill_we_low", 32'(vram_we), 32'd0);
    @(posedge clk_cpu); #1;
    check("fill_done_one_cycle", 32'(fill_done), 32'd0);
    rd(REG_CMD, 8'h02, "overrun_set");
    rd(REG_ADDR_LO, 8'h40, "fill_ptr_lo");
    rd(REG_ADDR_HI, 8'h3F, "fill_ptr_hi");
    rd(REG_FILL_LEN_LO, 8'h40, "len_lo_kept");
    rd(REG_FILL_LEN_HI, 8'h1F, "len_hi_kept");
    rd(REG_FILL_VAL, 8'h00, "fill_val_kept");
    set_wr(REG_CTRL, 8'h81);
    rd(REG_CMD, 8'h00, "overrun_cleared");
    rd(REG_CTRL, 8'h01, "ctrl_bit7_not_stored");

    // Zero-length START does nothing
    set_wr(REG_FILL_LEN_LO, 8'h00);
    set_wr(REG_FILL_LEN_HI, 8'h00);
    set_wr(REG_CMD, 8'h00);
    idle();
    bad = 0;
    repeat (6) begin
      @(posedge clk_cpu); #1;
      if (vram_we !== 1'b0 || busy !== 1'b0 || fill_done !== 1'b0) bad++;
    end
    check("len0_no_activity", 32'(bad), 32'd0);
    rd(REG_ADDR_LO, 8'h40, "len0_ptr_lo");

    // Reset while a 10-byte fill is on its third byte
    set_wr(REG_FILL_VAL, 8'hA5);
    set_wr(REG_FILL_LEN_LO, 8'h0A);
    set_wr(REG_ADDR_LO, 8'h00);
    set_wr(REG_ADDR_HI, 8'h05);
    set_wr(REG_CMD, 8'h00);
    @(posedge clk_cpu); #1; chk_wr(15'h0500, 8'hA5, "rfill_b1");
    idle();
    @(posedge clk_cpu); #1;
    @(posedge clk_cpu); #1; chk_wr(15'h0502, 8'hA5, "rfill_b3");
    rst_n = 1'b0;
    #1;
    check("rfill_we_abort", 32'(vram_we), 32'd0);
    check("rfill_busy_abort", 32'(busy), 32'd0);
    check("rfill_addr_reset", 32'(vram_addr), 32'd0);
    rd(REG_FILL_VAL, 8'h00, "rfill_val_reset");
    rd(REG_FILL_LEN_LO, 8'h00, "rfill_len_reset");
    rd(REG_ADDR_HI, 8'h00, "rfill_ptr_reset");
    idle();
    rst_n = 1'b1;
    nwr = 0;
    repeat (15) begin
      @(posedge clk_cpu); #1;
      if (vram_we !== 1'b0 || busy !== 1'b0 || fill_done !== 1'b0) nwr++;
    end
    check("rfill_no_writes_after", 32'(nwr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
